mcu_decode_seq: RTL and testbench

//  Multi-cycle fetch/decode sequencer for the 8-bit MCU. Sits directly upstream of the 8x8 register file.

---
 rtl/mcu_pkg.sv | 34 +++
 rtl/mcu_instr_field_dec.sv | 29 ++
 rtl/mcu_decode_seq.sv | 70 +++++++
 tb/tb_mcu_decode_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared opcode, ALU, state and instruction field definitions for the MCU
package mcu_pkg;
  localparam int OP_LSB = 12;
  localparam int D_LSB  = 9;
  localparam int A_LSB  = 6;
  localparam int B_LSB  = 3;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD      = 3'd0;
  localparam logic [2:0] ALU_SUB      = 3'd1;
  localparam logic [2:0] ALU_AND      = 3'd2;
  localparam logic [2:0] ALU_OR       = 3'd3;
  localparam logic [2:0] ALU_XOR      = 3'd4;
  localparam logic [2:0] ALU_PASS_A   = 3'd5;
  localparam logic [2:0] ALU_PASS_IMM = 3'd6;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    return op == OP_SUB ? ALU_SUB :
           op == OP_AND ? ALU_AND :
           op == OP_OR  ? ALU_OR  :
           op == OP_XOR ? ALU_XOR :
           op == OP_MOV ? ALU_PASS_A :
           op == OP_LDI ? ALU_PASS_IMM : ALU_ADD;
  endfunction
endpackage

// File: rtl/mcu_instr_field_dec.sv
// mcu_instr_field_dec: combinational field and opcode decode of one instruction word
module mcu_instr_field_dec
  import mcu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  d,
  output logic [2:0]  a,
  output logic [2:0]  b,
  output logic [7:0]  imm,
  output logic [2:0]  alu_op,
  output logic        wr,
  output logic        illegal,
  output logic        halt,
  output logic        jmp,
  output logic        bz
);
  logic [3:0] op;
  assign op      = instr[OP_LSB +: 4];
  assign d       = instr[D_LSB +: 3];
  assign a       = instr[A_LSB +: 3];
  assign b       = instr[B_LSB +: 3];
  assign imm     = instr[7:0];
  assign alu_op  = alu_of(op);
  assign wr      = op >= OP_ADD && op <= OP_MOV && d != 3'd0;
  assign illegal = op > OP_BZ && op < OP_HALT;
  assign halt    = op == OP_HALT;
  assign jmp     = op == OP_JMP;
  assign bz      = op == OP_BZ;
endmodule

// File: rtl/mcu_decode_seq.sv
// mcu_decode_seq: multi-cycle fetch/decode sequencer driving the 8x8 register file
module mcu_decode_seq
  import mcu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               instr_req,
  output logic [PC_W-1:0]    pc,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               zero_flag,
  output logic [2:0]         A_add,
  output logic [2:0]         B_add,
  output logic [2:0]         D_add,
  output logic               write_enable,
  output logic [2:0]         alu_op,
  output logic [7:0]         imm,
  output logic               halted,
  output logic               illegal_op
);
  state_t state, state_nxt;
  logic [INSTR_W-1:0] instr;
  logic wr, illegal, halt, jmp, bz;
  logic [PC_W-1:0] pc_nxt;
  mcu_instr_field_dec u_dec (
    .instr   (instr[15:0]),
    .d       (D_add),
    .a       (A_add),
    .b       (B_add),
    .imm     (imm),
    .alu_op  (alu_op),
    .wr      (wr),
    .illegal (illegal),
    .halt    (halt),
    .jmp     (jmp),
    .bz      (bz)
  );
  assign pc_nxt       = (jmp || (bz && zero_flag)) ? imm[PC_W-1:0] : pc + 1'b1;
  assign write_enable = state == S_WB;
  assign halted       = state == S_HALT;
  assign illegal_op   = state == S_DECODE && illegal;
  // next-state: fetch handshake, halt check in decode, writeback only for real register writes
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = (instr_req && instr_valid) ? S_DECODE : S_FETCH;
      S_DECODE: state_nxt = halt ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = wr ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = state;
    endcase
  end
  // state, registered fetch request, instruction latch and pc update in exec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      instr_req <= 1'b0;
      instr     <= '0;
      pc        <= '0;
    end else begin
      state     <= state_nxt;
      instr_req <= state_nxt == S_FETCH;
      if (state == S_FETCH && instr_req && instr_valid) instr <= instr_data;
      if (state == S_EXEC) pc <= pc_nxt;
    end
  end
endmodule

// File: tb/tb_mcu_decode_seq.sv
// tb_mcu_decode_seq: scoreboard bench for the fetch/decode sequencer
module tb_mcu_decode_seq;
  logic clk = 0, rst_n = 0, instr_req, instr_valid = 0, zero_flag = 0;
  logic [7:0] pc, imm;
  logic [15:0] instr_data = '0;
  logic [2:0] A_add, B_add, D_add, alu_op;
  logic write_enable, halted, illegal_op;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [2:0] d, a, b, alu; logic [7:0] imm; int c;} wr_t;
  wr_t wr_q[$];
  logic [7:0] fetch_q[$];
  int ill_q[$];
  wr_t mw;

  mcu_decode_seq dut (
    .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .pc(pc),
    .instr_valid(instr_valid), .instr_data(instr_data), .zero_flag(zero_flag),
    .A_add(A_add), .B_add(B_add), .D_add(D_add), .write_enable(write_enable),
    .alu_op(alu_op), .imm(imm), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic miss(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", n);
  endtask

  // monitor: compare every fetch handshake, write strobe and illegal pulse against the scoreboard
  always @(negedge clk) if (rst_n) begin
    if (instr_req && instr_valid) begin
      if (fetch_q.size() == 0) miss("fetch_unexpected");
      else chk("fetch_pc", pc, fetch_q.pop_front());
    end
    if (write_enable) begin
      if (wr_q.size() == 0) miss("write_unexpected");
      else begin
        mw = wr_q.pop_front();
        chk("wb_cycle", cyc, mw.c);
        chk("wb_D_add", D_add, mw.d);
        chk("wb_A_add", A_add, mw.a);
        chk("wb_B_add", B_add, mw.b);
        chk("wb_alu_op", alu_op, mw.alu);
        chk("wb_imm", imm, mw.imm);
      end
    end
    if (illegal_op) begin
      if (ill_q.size() == 0) miss("illegal_unexpected");
      else chk("illegal_cycle", cyc, ill_q.pop_front());
    end
  end

  // issue one instruction; starts and ends #1 after a posedge
  task automatic issue(input logic [15:0] w, input int waits, input logic zf,
                       input logic [7:0] exp_pc, input int lat, input logic wr,
                       input logic [2:0] alu, input logic ill);
    int n, fc;
    zero_flag = zf;
    n = 0;
    while (!instr_req && n < 20) begin @(posedge clk); #1; n++; end
    if (!instr_req) chk("req_timeout", {31'd0, instr_req}, 1);
    fetch_q.push_back(exp_pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("req_held", {31'd0, instr_req}, 1);
      @(posedge clk); #1;
    end
    instr_valid = 1;
    instr_data = w;
    fc = cyc;
    if (wr) wr_q.push_back('{w[11:9], w[8:6], w[5:3], alu, w[7:0], fc + 3});
    if (ill) ill_q.push_back(fc + 1);
    @(posedge clk); #1;
    instr_valid = 0;
    instr_data = 16'h6E55;
    if (lat > 0) begin
      n = 0;
      while (!instr_req && n < 10) begin @(posedge clk); #1; n++; end
      chk("latency", cyc - fc, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, instr_req}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_fields", {A_add, B_add, D_add, alu_op, imm}, 0);
    chk("rst_flags", {write_enable, halted, illegal_op}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("req_after_release", {31'd0, instr_req}, 0);
    @(posedge clk); #1;
    issue(16'h662A, 0, 0, 8'h00, 4, 1, 3'd6, 0);
    issue(16'h1298, 2, 0, 8'h01, 4, 1, 3'd0, 0);
    issue(16'h1098, 0, 0, 8'h02, 3, 0, 3'd0, 0);
    issue(16'hA000, 0, 0, 8'h03, 3, 0, 3'd0, 1);
    issue(16'h8010, 0, 0, 8'h04, 3, 0, 3'd0, 0);
    issue(16'h9040, 0, 1, 8'h10, 3, 0, 3'd0, 0);
    issue(16'h9080, 0, 0, 8'h40, 3, 0, 3'd0, 0);
    issue(16'h7BC0, 0, 1, 8'h41, 4, 1, 3'd5, 0);
    issue(16'h2C50, 1, 0, 8'h42, 4, 1, 3'd1, 0);
    issue(16'h80FF, 0, 0, 8'h43, 3, 0, 3'd0, 0);
    issue(16'h0000, 0, 0, 8'hFF, 3, 0, 3'd0, 0);
    issue(16'h54E0, 0, 0, 8'h00, 4, 1, 3'd4, 0);
    issue(16'h6E55, 0, 0, 8'h01, 0, 0, 3'd0, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("wb_before_reset", {31'd0, write_enable}, 1);
    rst_n = 0;
    #1;
    chk("async_rst_we", {31'd0, write_enable}, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_req", {31'd0, instr_req}, 0);
    chk("async_rst_D_add", D_add, 0);
    @(posedge clk); #1;
    rst_n = 1;
    issue(16'h0000, 0, 0, 8'h00, 3, 0, 3'd0, 0);
    issue(16'hF000, 0, 0, 8'h01, 0, 0, 3'd0, 0);
    @(posedge clk); #1;
    chk("halted", {31'd0, halted}, 1);
    instr_valid = 1;
    instr_data = 16'h662A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_state", {halted, instr_req, write_enable}, 3'b100);
      chk("halt_pc", pc, 8'h01);
      @(posedge clk); #1;
    end
    instr_valid = 0;
    rst_n = 0;
    #1;
    chk("unhalt_rst", {halted, pc}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) begin @(posedge clk); #1; end
    chk("req_after_unhalt", {31'd0, instr_req}, 1);
    chk("fetch_q_left", fetch_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    chk("ill_q_left", ill_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
